rr_stream_mux: RTL and testbench

RR_STREAM_MUX -- requirements
Module: rr_stream_mux

---
 rtl/rr_stream_mux.sv | 86 ++++++++
 tb/tb_rr_stream_mux.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel stream arbiter (round-robin or fixed priority)
// that feeds one registered output slot with a valid/ready handshake.
module rr_stream_mux #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  localparam logic [SW:0]   N_L  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0] ptr_r;
  logic [SW-1:0] base_s;
  logic [SW-1:0] grant_idx_s;
  logic [SW-1:0] next_ptr_s;
  logic          grant_found_s;
  logic          load_en_s;
  logic          xfer_s;
  logic [W-1:0]  grant_data_s;

  // Grant search: first valid channel starting at base, wrapping modulo N
  always_comb begin
    logic [SW:0] cand_s;
    cand_s        = '0;
    base_s        = (MODE == 1) ? '0 : ptr_r;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, base_s} + (SW+1)'(k);
      cand_s = (cand_s >= N_L) ? (cand_s - N_L) : cand_s;
      if (!grant_found_s && in_valid[cand_s[SW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[SW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Data mux and handshake decode; in_ready never looks at in_data
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx_s == SW'(i)) begin
        grant_data_s = in_data[i*W +: W];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
    load_en_s  = !out_valid || out_ready;
    xfer_s     = grant_found_s && load_en_s && !rst;
    next_ptr_s = (grant_idx_s == LAST) ? '0 : (grant_idx_s + 1'b1);
    in_ready   = xfer_s ? ({{(N-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
  end

  // Output slot and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_r     <= '0;
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_s;
      out_sel   <= grant_idx_s;
      ptr_r     <= next_ptr_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux: one round-robin and one fixed-priority instance,
// expected beats queued at stimulus time and compared on each handshake.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid0, in_valid1, in_ready0, in_ready1;
  logic        out_ready0, out_ready1, out_valid0, out_valid1;
  logic [7:0]  out_data0, out_data1;
  logic [1:0]  out_sel0, out_sel1;

  int checks = 0;
  int errors = 0;
  logic [9:0] sbq[$];
  logic [9:0] exp_beat;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(4), .W(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_sel(out_sel0), .out_ready(out_ready0)
  );

  rr_stream_mux #(.N(4), .W(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_sel(out_sel1), .out_ready(out_ready1)
  );

  task automatic test_reset();
    rst = 1'b1; in_data = 32'hA3A2A1A0;
    in_valid0 = 4'b0000; in_valid1 = 4'b0000;
    out_ready0 = 1'b0; out_ready1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({out_valid0, out_data0, out_sel0, in_ready0} !== {1'b0, 8'h00, 2'd0, 4'b0000}) begin
        errors++;
        $display("FAIL reset_dut0: got v=%b d=%h s=%0d r=%b, expected 0 00 0 0000",
                 out_valid0, out_data0, out_sel0, in_ready0);
      end
      checks++;
      if ({out_valid1, out_data1, out_sel1, in_ready1} !== {1'b0, 8'h00, 2'd0, 4'b0000}) begin
        errors++;
        $display("FAIL reset_dut1: got v=%b d=%h s=%0d r=%b, expected 0 00 0 0000",
                 out_valid1, out_data1, out_sel1, in_ready1);
      end
    end
    in_valid0 = 4'b1111; in_valid1 = 4'b1111; out_ready0 = 1'b1; out_ready1 = 1'b1; #1;
    checks++;
    if ({in_ready0, in_ready1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b, expected 0000/0000", in_ready0, in_ready1);
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold_valid: got %b%b, expected 00", out_valid0, out_valid1);
    end
    rst = 1'b0; in_valid0 = 4'b0000; in_valid1 = 4'b0000; out_ready0 = 1'b0; out_ready1 = 1'b0;
  endtask

  task automatic test_round_robin();
    sbq.push_back({2'd0, 8'hA0}); sbq.push_back({2'd1, 8'hA1});
    sbq.push_back({2'd2, 8'hA2}); sbq.push_back({2'd3, 8'hA3});
    sbq.push_back({2'd0, 8'hA0}); sbq.push_back({2'd1, 8'hA1});
    in_valid0 = 4'b1111; out_ready0 = 1'b1; #1;
    checks++;
    if (in_ready0 !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_grant: got %b, expected 0001", in_ready0);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      checks++;
      if (in_ready0 !== (4'b0001 << (k % 4))) begin
        errors++;
        $display("FAIL rr_ready beat %0d: got %b, expected %b", k, in_ready0, 4'b0001 << (k % 4));
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rr_beat: scoreboard empty");
      end else begin
        exp_beat = sbq.pop_front();
        if ({out_valid0, out_sel0, out_data0} !== {1'b1, exp_beat}) begin
          errors++;
          $display("FAIL rr_beat %0d: got v=%b s=%0d d=%h, expected v=1 s=%0d d=%h",
                   k, out_valid0, out_sel0, out_data0, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
    in_valid0 = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got out_valid=%b, expected 0", out_valid0);
    end
  endtask

  task automatic test_backpressure();
    sbq.push_back({2'd2, 8'hA2}); sbq.push_back({2'd3, 8'hA3});
    in_valid0 = 4'b1111; out_ready0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({out_valid0, out_sel0, out_data0, in_ready0} !== {1'b1, 2'd2, 8'hA2, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold: got v=%b s=%0d d=%h r=%b, expected 1 2 a2 0000",
                 out_valid0, out_sel0, out_data0, in_ready0);
      end
    end
    out_ready0 = 1'b1; #1;
    checks++;
    if (in_ready0 !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, expected 1000", in_ready0);
    end
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL bp_beat: scoreboard empty");
      end else begin
        exp_beat = sbq.pop_front();
        if ({out_valid0, out_sel0, out_data0} !== {1'b1, exp_beat}) begin
          errors++;
          $display("FAIL bp_beat: got v=%b s=%0d d=%h, expected v=1 s=%0d d=%h",
                   out_valid0, out_sel0, out_data0, exp_beat[9:8], exp_beat[7:0]);
        end
      end
      if (c == 0) begin
        @(negedge clk); #1;
      end
    end
    in_valid0 = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b, expected 0", out_valid0);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pat [3];
    logic [3:0] rdy [3];
    pat[0] = 4'b0100; pat[1] = 4'b0010; pat[2] = 4'b1111;
    rdy[0] = 4'b0100; rdy[1] = 4'b0010; rdy[2] = 4'b0100;
    sbq.push_back({2'd2, 8'hA2}); sbq.push_back({2'd1, 8'hA1}); sbq.push_back({2'd2, 8'hA2});
    out_ready0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid0 = pat[k]; #1;
      checks++;
      if (in_ready0 !== rdy[k]) begin
        errors++;
        $display("FAIL wrap_ready step %0d: got %b, expected %b", k, in_ready0, rdy[k]);
      end
      @(negedge clk); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL wrap_beat: scoreboard empty");
      end else begin
        exp_beat = sbq.pop_front();
        if ({out_valid0, out_sel0, out_data0} !== {1'b1, exp_beat}) begin
          errors++;
          $display("FAIL wrap_beat step %0d: got v=%b s=%0d d=%h, expected v=1 s=%0d d=%h",
                   k, out_valid0, out_sel0, out_data0, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
    in_valid0 = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if ({out_valid0, in_ready0} !== 5'b0_0000) begin
      errors++;
      $display("FAIL idle: got v=%b r=%b, expected 0 0000", out_valid0, in_ready0);
    end
    @(negedge clk);
    in_valid0 = 4'b1111; out_ready0 = 1'b0; #1;
    checks++;
    if (in_ready0 !== 4'b1000) begin
      errors++;
      $display("FAIL idle_ptr_kept: got %b, expected 1000", in_ready0);
    end
    in_valid0 = 4'b0010;
    @(negedge clk); #1;
    checks++;
    if ({out_valid0, out_sel0, out_data0, in_ready0} !== {1'b1, 2'd1, 8'hA1, 4'b0000}) begin
      errors++;
      $display("FAIL wrap_hold: got v=%b s=%0d d=%h r=%b, expected 1 1 a1 0000",
               out_valid0, out_sel0, out_data0, in_ready0);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; in_valid0 = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if ({out_valid0, out_data0, out_sel0, in_ready0} !== {1'b0, 8'h00, 2'd0, 4'b0000}) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%b d=%h s=%0d r=%b, expected 0 00 0 0000",
               out_valid0, out_data0, out_sel0, in_ready0);
    end
    rst = 1'b0; in_valid0 = 4'b1111; out_ready0 = 1'b1;
    sbq.push_back({2'd0, 8'hA0}); #1;
    checks++;
    if (in_ready0 !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_ptr: got %b, expected 0001", in_ready0);
    end
    @(negedge clk); #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL rstmid_beat: scoreboard empty");
    end else begin
      exp_beat = sbq.pop_front();
      if ({out_valid0, out_sel0, out_data0} !== {1'b1, exp_beat}) begin
        errors++;
        $display("FAIL rstmid_beat: got v=%b s=%0d d=%h, expected v=1 s=%0d d=%h",
                 out_valid0, out_sel0, out_data0, exp_beat[9:8], exp_beat[7:0]);
      end
    end
    in_valid0 = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drain: got out_valid=%b, expected 0", out_valid0);
    end
  endtask

  task automatic test_priority();
    for (int k = 0; k < 5; k++) sbq.push_back({2'd1, 8'hA1});
    in_valid1 = 4'b0110; out_ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready1 !== 4'b0010) begin
        errors++;
        $display("FAIL prio_ready %0d: got %b, expected 0010", k, in_ready1);
      end
      @(negedge clk); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL prio_beat: scoreboard empty");
      end else begin
        exp_beat = sbq.pop_front();
        if ({out_valid1, out_sel1, out_data1} !== {1'b1, exp_beat}) begin
          errors++;
          $display("FAIL prio_beat %0d: got v=%b s=%0d d=%h, expected v=1 s=%0d d=%h",
                   k, out_valid1, out_sel1, out_data1, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
    in_valid1 = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_priority();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d beats, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
